multicycle_ctrl_fsm: RTL and testbench

//  Multicycle CPU control unit. Moore FSM sequencing fetch/decode/execute/memory/writeback.

---
 rtl/multicycle_ctrl_fsm_pkg.sv | 41 ++++
 rtl/multicycle_ctrl_fsm.sv | 155 +++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, datapath select
// codes and FSM state encodings (also used by the datapath and the bench).
package multicycle_ctrl_fsm_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;

    localparam logic [1:0] ALUSRCB_DATAB = 2'b00;
    localparam logic [1:0] ALUSRCB_CONST = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        MEMADDR = 4'd3,
        MEMRD   = 4'd4,
        MEMWB   = 4'd5,
        MEMWR   = 4'd6,
        EXEC_R  = 4'd7,
        ALUWB_R = 4'd8,
        EXEC_I  = 4'd9,
        ALUWB_I = 4'd10,
        BRANCH  = 4'd11,
        JUMP    = 4'd12,
        TRAP    = 4'd13
    } ctrlState_e;

endpackage

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle CPU control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, gated by the memory ready handshake.
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int unsigned OP_W   = 6,
    parameter int unsigned ST_W   = 4,
    parameter int unsigned IRQ_EN = 0
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic [OP_W-1:0] Opcode,
    input  logic            Zero,
    input  logic            MemReady,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IorD,
    output logic            IRWrite,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic [1:0]      PCSource,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ALUOp,
    output logic            RegDst,
    output logic            MemtoReg,
    output logic            RegWrite,
    output logic            Illegal,
    output logic [ST_W-1:0] State
);

    ctrlState_e state;
    ctrlState_e nextState;

    // Zero is consumed by the datapath through PCWriteCond; IRQ_EN is reserved.
    logic unusedSignals;
    assign unusedSignals = ^{Zero, (IRQ_EN != 0)};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Illegal <= 1'b0;
        end else if (nextState == TRAP) begin
            Illegal <= 1'b1;
        end
    end

    always_comb begin
        nextState = FETCH;
        case (state)
            IDLE:    nextState = FETCH;
            FETCH:   nextState = MemReady ? DECODE : FETCH;
            DECODE: begin
                if (Opcode == OPC_LW || Opcode == OPC_SW) nextState = MEMADDR;
                else if (Opcode == OPC_RTYPE)             nextState = EXEC_R;
                else if (Opcode == OPC_ADDI)              nextState = EXEC_I;
                else if (Opcode == OPC_BEQ)               nextState = BRANCH;
                else if (Opcode == OPC_J)                 nextState = JUMP;
                else                                      nextState = TRAP;
            end
            MEMADDR: nextState = (Opcode == OPC_LW) ? MEMRD : MEMWR;
            MEMRD:   nextState = MemReady ? MEMWB : MEMRD;
            MEMWB:   nextState = FETCH;
            MEMWR:   nextState = MemReady ? FETCH : MEMWR;
            EXEC_R:  nextState = ALUWB_R;
            ALUWB_R: nextState = FETCH;
            EXEC_I:  nextState = ALUWB_I;
            ALUWB_I: nextState = FETCH;
            BRANCH:  nextState = FETCH;
            JUMP:    nextState = FETCH;
            TRAP:    nextState = TRAP;
            default: nextState = FETCH;
        endcase
    end

    always_comb begin
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = PCSRC_ALU;
        ALUSrcA     = 1'b0;
        ALUSrcB     = ALUSRCB_DATAB;
        ALUOp       = ALUOP_ADD;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = ALUSRCB_CONST;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            DECODE: begin
                ALUSrcB = ALUSRCB_IMM;
            end
            MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = ALUSRCB_IMM;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            ALUWB_R: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = ALUSRCB_IMM;
            end
            ALUWB_I: begin
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            default: begin
            end
        endcase
    end

    assign State = ST_W'(state);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: per-cycle state/strobe vectors for
// each instruction class, reset behaviour, trap stickiness and a random soak.
module tb_multicycle_ctrl_fsm;
    import multicycle_ctrl_fsm_pkg::*;

    logic       Clk;
    logic       Rst_n;
    logic [5:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic       MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond;
    logic [1:0] PCSource, ALUSrcB, ALUOp;
    logic       ALUSrcA, RegDst, MemtoReg, RegWrite, Illegal;
    logic [3:0] State;

    int checks = 0;
    int passes = 0;

    // Output vector layout: mr mw iord irw pcw pcwc _ pcs _ asa _ asb _ aop _ rd m2r rw ill
    localparam logic [16:0] O_ZERO    = 17'b000000_00_0_00_00_0000;
    localparam logic [16:0] O_FETCH   = 17'b100110_00_0_01_00_0000;
    localparam logic [16:0] O_FSTALL  = 17'b100000_00_0_01_00_0000;
    localparam logic [16:0] O_DECODE  = 17'b000000_00_0_10_00_0000;
    localparam logic [16:0] O_MEMADDR = 17'b000000_00_1_10_00_0000;
    localparam logic [16:0] O_MEMRD   = 17'b101000_00_0_00_00_0000;
    localparam logic [16:0] O_MEMWB   = 17'b000000_00_0_00_00_0110;
    localparam logic [16:0] O_MEMWR   = 17'b011000_00_0_00_00_0000;
    localparam logic [16:0] O_EXEC_R  = 17'b000000_00_1_00_10_0000;
    localparam logic [16:0] O_ALUWB_R = 17'b000000_00_0_00_00_1010;
    localparam logic [16:0] O_EXEC_I  = 17'b000000_00_1_10_00_0000;
    localparam logic [16:0] O_ALUWB_I = 17'b000000_00_0_00_00_0010;
    localparam logic [16:0] O_BRANCH  = 17'b000001_01_1_00_01_0000;
    localparam logic [16:0] O_JUMP    = 17'b000010_10_0_00_00_0000;
    localparam logic [16:0] O_TRAP    = 17'b000000_00_0_00_00_0001;

    multicycle_ctrl_fsm #(.OP_W(6), .ST_W(4), .IRQ_EN(0)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .Illegal(Illegal), .State(State)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [20:0] obs();
        return {State, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond,
                PCSource, ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite, Illegal};
    endfunction

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; Opcode = OPC_RTYPE; Zero = 1'b0; MemReady = 1'b1;
        repeat (2) @(negedge Clk);
        checks++;
        if (obs() !== {IDLE, O_ZERO}) $display("FAIL reset_hold: got %h want %h", obs(), {IDLE, O_ZERO});
        else passes++;
        Rst_n = 1'b1; #1;
        checks++;
        if (State !== IDLE) $display("FAIL reset_release_idle: got %0d want %0d", State, IDLE);
        else passes++;
        step();
        checks++;
        if (obs() !== {FETCH, O_FETCH}) $display("FAIL reset_then_fetch: got %h want %h", obs(), {FETCH, O_FETCH});
        else passes++;
    endtask

    task automatic test_rtype();
        logic [20:0] expSeq [4];
        expSeq = '{{FETCH, O_FETCH}, {DECODE, O_DECODE}, {EXEC_R, O_EXEC_R}, {ALUWB_R, O_ALUWB_R}};
        Opcode = OPC_RTYPE; MemReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (obs() !== expSeq[i]) $display("FAIL rtype cycle %0d: got %h want %h", i, obs(), expSeq[i]);
            else passes++;
            step();
        end
        checks++;
        if (State !== FETCH) $display("FAIL rtype_done: got %0d want %0d", State, FETCH);
        else passes++;
    endtask

    task automatic test_lw_wait();
        logic [20:0] expSeq [8];
        logic        rdySeq [8];
        expSeq = '{{FETCH, O_FETCH}, {DECODE, O_DECODE}, {MEMADDR, O_MEMADDR}, {MEMRD, O_MEMRD},
                   {MEMRD, O_MEMRD}, {MEMRD, O_MEMRD}, {MEMRD, O_MEMRD}, {MEMWB, O_MEMWB}};
        rdySeq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        Opcode = OPC_LW;
        for (int i = 0; i < 8; i++) begin
            MemReady = rdySeq[i]; #1;
            checks++;
            if (obs() !== expSeq[i]) $display("FAIL lw_wait cycle %0d: got %h want %h", i, obs(), expSeq[i]);
            else passes++;
            step();
        end
        checks++;
        if (State !== FETCH) $display("FAIL lw_done: got %0d want %0d", State, FETCH);
        else passes++;
    endtask

    task automatic test_sw_fetch_stall();
        logic [20:0] expSeq [6];
        logic        rdySeq [6];
        expSeq = '{{FETCH, O_FSTALL}, {FETCH, O_FSTALL}, {FETCH, O_FETCH},
                   {DECODE, O_DECODE}, {MEMADDR, O_MEMADDR}, {MEMWR, O_MEMWR}};
        rdySeq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        Opcode = OPC_SW;
        for (int i = 0; i < 6; i++) begin
            MemReady = rdySeq[i]; #1;
            checks++;
            if (obs() !== expSeq[i]) $display("FAIL sw cycle %0d: got %h want %h", i, obs(), expSeq[i]);
            else passes++;
            step();
        end
        checks++;
        if (State !== FETCH) $display("FAIL sw_done: got %0d want %0d", State, FETCH);
        else passes++;
    endtask

    task automatic test_beq();
        logic [20:0] expSeq [3];
        expSeq = '{{FETCH, O_FETCH}, {DECODE, O_DECODE}, {BRANCH, O_BRANCH}};
        Opcode = OPC_BEQ; MemReady = 1'b1; Zero = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (obs() !== expSeq[i]) $display("FAIL beq cycle %0d: got %h want %h", i, obs(), expSeq[i]);
            else passes++;
            step();
        end
        Zero = 1'b0;
        checks++;
        if (State !== FETCH) $display("FAIL beq_done: got %0d want %0d", State, FETCH);
        else passes++;
    endtask

    task automatic test_jump_addi();
        logic [20:0] expSeq [7];
        logic [5:0]  opSeq  [7];
        expSeq = '{{FETCH, O_FETCH}, {DECODE, O_DECODE}, {JUMP, O_JUMP},
                   {FETCH, O_FETCH}, {DECODE, O_DECODE}, {EXEC_I, O_EXEC_I}, {ALUWB_I, O_ALUWB_I}};
        opSeq  = '{OPC_J, OPC_J, OPC_J, OPC_ADDI, OPC_ADDI, OPC_ADDI, OPC_ADDI};
        MemReady = 1'b1;
        for (int i = 0; i < 7; i++) begin
            Opcode = opSeq[i]; #1;
            checks++;
            if (obs() !== expSeq[i]) $display("FAIL j_addi cycle %0d: got %h want %h", i, obs(), expSeq[i]);
            else passes++;
            step();
        end
        checks++;
        if (State !== FETCH) $display("FAIL addi_done: got %0d want %0d", State, FETCH);
        else passes++;
    endtask

    task automatic test_trap();
        Opcode = 6'b111111; MemReady = 1'b1;
        step(); step();
        for (int i = 0; i < 4; i++) begin
            MemReady = 1'(i % 2); #1;
            checks++;
            if (obs() !== {TRAP, O_TRAP}) $display("FAIL trap cycle %0d: got %h want %h", i, obs(), {TRAP, O_TRAP});
            else passes++;
            step();
        end
        #2 Rst_n = 1'b0; #1;
        checks++;
        if (obs() !== {IDLE, O_ZERO}) $display("FAIL trap_reset_clears: got %h want %h", obs(), {IDLE, O_ZERO});
        else passes++;
        @(negedge Clk);
        Rst_n = 1'b1; Opcode = OPC_RTYPE;
        step();
        checks++;
        if (State !== FETCH || Illegal !== 1'b0)
            $display("FAIL trap_after_reset: got state %0d ill %b want state %0d ill 0", State, Illegal, FETCH);
        else passes++;
    endtask

    task automatic test_reset_mid_request();
        Opcode = OPC_LW; MemReady = 1'b1;
        step(); step();
        MemReady = 1'b0;
        step();
        checks++;
        if (obs() !== {MEMRD, O_MEMRD}) $display("FAIL midreq_in_memrd: got %h want %h", obs(), {MEMRD, O_MEMRD});
        else passes++;
        #2 Rst_n = 1'b0; #1;
        checks++;
        if (obs() !== {IDLE, O_ZERO}) $display("FAIL midreq_async_drop: got %h want %h", obs(), {IDLE, O_ZERO});
        else passes++;
        @(negedge Clk);
        Rst_n = 1'b1; MemReady = 1'b1; #1;
        checks++;
        if (State !== IDLE) $display("FAIL midreq_release_idle: got %0d want %0d", State, IDLE);
        else passes++;
        step();
        checks++;
        if (State !== FETCH) $display("FAIL midreq_then_fetch: got %0d want %0d", State, FETCH);
        else passes++;
    endtask

    task automatic test_soak();
        logic [5:0] legal [6];
        int         decodes = 0;
        legal = '{OPC_RTYPE, OPC_LW, OPC_SW, OPC_BEQ, OPC_J, OPC_ADDI};
        for (int c = 0; c < 1000; c++) begin
            if (State == FETCH) Opcode = legal[$urandom_range(0, 5)];
            MemReady = 1'($urandom_range(0, 1));
            Zero     = 1'($urandom_range(0, 1));
            #1;
            if (State == DECODE) decodes++;
            checks++;
            if (ALUSrcB === 2'b11) $display("FAIL soak_alusrcb cycle %0d: got %b want not 11", c, ALUSrcB);
            else passes++;
            checks++;
            if ((MemRead & MemWrite) !== 1'b0)
                $display("FAIL soak_rd_wr cycle %0d: got rd %b wr %b want not both", c, MemRead, MemWrite);
            else passes++;
            checks++;
            if ((RegWrite & MemWrite) !== 1'b0 || Illegal !== 1'b0)
                $display("FAIL soak_rw_ill cycle %0d: got rw %b wr %b ill %b", c, RegWrite, MemWrite, Illegal);
            else passes++;
            step();
        end
        checks++;
        if (decodes < 50) $display("FAIL soak_progress: got %0d decodes want >= 50", decodes);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw_fetch_stall();
        test_beq();
        test_jump_addi();
        test_trap();
        test_reset_mid_request();
        test_soak();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
